logic_acc_unit: RTL and testbench

Parametrised, clocked successor to the team's two-input AND primitives. Computes one of four bitwise operations (AND, OR, XOR, NAND) on WIDTH-bit operands. Runs either as a single-shot two-operand unit or as a frame accumulator that folds a stream of words into one result. Sits between a valid/ready producer and consumer in the datapath, and replaces ad-hoc wire/reg gate instances where a registered, flow-controlled result is needed.

---
 rtl/logic_acc_unit.sv | 79 +++++++
 tb/tb_logic_acc_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/logic_acc_unit.sv
// logic_acc_unit: registered AND/OR/XOR/NAND unit, single-shot or frame-fold, valid/ready on both sides.
// Define LOGIC_ACC_CNT_EN to add the saturating beat counter output cnt.
module logic_acc_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
`ifdef LOGIC_ACC_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
    state_t state, state_n;
    logic [1:0] op_r, op_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic take;

    function automatic logic [WIDTH-1:0] f(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
        return o == 2'b00 ? x & z : o == 2'b01 ? x | z : o == 2'b10 ? x ^ z : ~(x & z);
    endfunction

    assign in_ready  = !rst && state != HOLD;
    assign take      = in_valid && in_ready;
    assign out_valid = state == HOLD;
    assign y         = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= 2'b00;
            acc   <= '0;
        end else begin
            state <= state_n;
            op_r  <= op_n;
            acc   <= acc_n;
        end
    end

    // op is captured on the first beat so mid-frame changes cannot alter the fold
    always_comb begin
        state_n = state;
        op_n    = op_r;
        acc_n   = acc;
        case (state)
            IDLE: if (take) begin
                op_n    = op;
                acc_n   = f(op, a, b);
                state_n = (!mode || in_last) ? HOLD : ACC;
            end
            ACC: if (take) begin
                acc_n   = f(op_r, acc, a);
                state_n = in_last ? HOLD : ACC;
            end
            HOLD:    state_n = out_ready ? IDLE : HOLD;
            default: state_n = IDLE;
        endcase
    end

`ifdef LOGIC_ACC_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (take)
            cnt <= state == IDLE ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
    end
`endif
endmodule

// File: tb/tb_logic_acc_unit.sv
// tb_logic_acc_unit: directed-vector bench for logic_acc_unit (CNT_W=2 so saturation is reachable).
module tb_logic_acc_unit;
    logic       clk = 0;
    logic       rst;
    logic [1:0] op;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
`ifdef LOGIC_ACC_CNT_EN
    logic [1:0] cnt;
`endif
    int n_chk = 0;
    int n_pass = 0;

    logic_acc_unit #(.WIDTH(8), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .op(op), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef LOGIC_ACC_CNT_EN
        , .cnt(cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // called at a negedge; offers one beat and advances past the sampling posedge
    task automatic drive(input logic [1:0] o, input logic m, input logic [7:0] av, input logic [7:0] bv, input logic l);
        in_valid = 1; op = o; mode = m; a = av; b = bv; in_last = l;
        @(negedge clk);
    endtask

    task automatic finish_frame(input string tag, input logic [7:0] ey, input logic [1:0] ec);
        in_valid = 0;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_ready_low"}, in_ready, 0);
`ifdef LOGIC_ACC_CNT_EN
        chk({tag, "_cnt"}, cnt, ec);
`else
        if (ec == 2'b00) $display("note: zero count for %s", tag);
`endif
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, "_done"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic [7:0] exp0 [4];
        exp0[0] = 8'h42; exp0[1] = 8'hDB; exp0[2] = 8'h99; exp0[3] = 8'hBD;
        rst = 1; op = 0; mode = 0; in_valid = 0; a = 0; b = 0; in_last = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_y", y, 0);
`ifdef LOGIC_ACC_CNT_EN
        chk("rst_cnt", cnt, 0);
`endif
        rst = 0;
        #1 chk("rel_ready", in_ready, 1);
        @(negedge clk);

        // single-shot, all ops; in_last=0 must not keep mode 0 open
        for (int i = 0; i < 4; i++) begin
            drive(2'(i), 0, 8'hC3, 8'h5A, 0);
            finish_frame($sformatf("m0_op%0d", i), exp0[i], 2'd1);
        end

        // XOR fold with op and b changed mid-frame
        drive(2'b10, 1, 8'h0F, 8'hF0, 0);
        chk("xor_mid_valid", out_valid, 0);
        drive(2'b00, 1, 8'hFF, 8'hFF, 0);
        drive(2'b01, 0, 8'h01, 8'hAA, 1);
        finish_frame("xor_fold", 8'h01, 2'd3);

        // NAND fold in beat order: ~(F0&0F)=FF, ~(FF&0F)=F0, ~(F0&3C)=CF
        drive(2'b11, 1, 8'hF0, 8'h0F, 0);
        drive(2'b11, 1, 8'h0F, 8'h00, 0);
        drive(2'b11, 1, 8'h3C, 8'h00, 1);
        finish_frame("nand_fold", 8'hCF, 2'd3);

        drive(2'b00, 1, 8'hFF, 8'h0F, 0);
        drive(2'b00, 1, 8'h3C, 8'h00, 1);
        finish_frame("and_two", 8'h0C, 2'd2);

        // back-pressure: 5 held cycles with beats offered
        drive(2'b10, 0, 8'h12, 8'h34, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; op = 2'b01; a = 8'hFF; b = 8'hFF;
            chk($sformatf("bp_valid%0d", i), out_valid, 1);
            chk($sformatf("bp_y%0d", i), y, 8'h26);
            chk($sformatf("bp_ready%0d", i), in_ready, 0);
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("bp_done", out_valid, 0);
        chk("bp_y_kept", y, 8'h26);
        chk("bp_idle_ready", in_ready, 1);
        @(negedge clk);
        chk("bp_no_accept", out_valid, 0);

        // reset mid-frame after two accumulate beats
        drive(2'b01, 1, 8'h01, 8'h02, 0);
        drive(2'b01, 1, 8'h04, 8'h00, 0);
        #2 rst = 1;
        #1 chk("rmid_valid", out_valid, 0);
        chk("rmid_ready", in_ready, 0);
        chk("rmid_y", y, 0);
        @(negedge clk);
        in_valid = 0; rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rmid_quiet%0d", i), out_valid, 0);
        end
        drive(2'b00, 1, 8'hFF, 8'h0F, 1);
        finish_frame("after_rst", 8'h0F, 2'd1);

        // reset while holding a result
        drive(2'b01, 0, 8'hA0, 8'h05, 0);
        in_valid = 0;
        chk("rhold_pre", out_valid, 1);
        #2 rst = 1;
        #1 chk("rhold_valid", out_valid, 0);
        chk("rhold_y", y, 0);
        @(negedge clk);
        rst = 0;

        // saturation: 6-beat OR frame
        drive(2'b01, 1, 8'h01, 8'h02, 0);
        drive(2'b01, 1, 8'h04, 8'h00, 0);
        drive(2'b01, 1, 8'h08, 8'h00, 0);
        drive(2'b01, 1, 8'h10, 8'h00, 0);
        drive(2'b01, 1, 8'h20, 8'h00, 0);
        drive(2'b01, 1, 8'h40, 8'h00, 1);
        finish_frame("or_sat", 8'h7F, 2'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "timeout");
    end
endmodule
